rgb_index_packer: RTL and testbench

Framebuffer write-side pixel encoder for the kinnow display path. Accepts a stream of RGB333 pixels, converts each to the 8-bit palette index that the scan-out palette maps back to RGB333, packs four indices per 32-bit word, and issues sequential framebuffer word writes with byte strobes. It sits between the rendering/blit source and the framebuffer memory port; the scan-out side reads those bytes and runs them through the palette.

---
 rtl/kinnow_pkg.sv | 28 ++
 rtl/rgb_index_packer.sv | 105 ++++++++++
 tb/tb_rgb_index_packer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kinnow_pkg.sv
// Shared kinnow display-path types and the RGB333 <-> palette-index mapping.
// Write side (pal_encode) and scan-out side (pal_decode) share this definition.
package kinnow_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  typedef logic [7:0] pal_idx_t;

  localparam int unsigned PIX_PER_WORD = 4;

  // R[0] has no slot in the index; scan-out regenerates it from B[0].
  function automatic pal_idx_t pal_encode(input rgb333_t c);
    return {c.g, c.r[2:1], c.b};
  endfunction

  function automatic rgb333_t pal_decode(input pal_idx_t i);
    rgb333_t c;
    c.r = {i[4:3], i[0]};
    c.g = i[7:5];
    c.b = i[2:0];
    return c;
  endfunction

endpackage

// File: rtl/rgb_index_packer.sv
// Framebuffer write-side encoder: RGB333 pixels -> palette indices, packed four
// per 32-bit word and written to sequential framebuffer word addresses.
module rgb_index_packer
  import kinnow_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned FB_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [8:0]        pix_rgb,
  input  logic              pix_last,
  input  logic              restart,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              frame_done
);

  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t BASE = addr_t'(FB_BASE);

  logic [1:0]  lane;
  logic [23:0] acc;
  logic        last_pend;
  logic        rewind_pend;
  logic        pix_fire;
  logic        wr_fire;
  logic        word_done;
  pal_idx_t    idx;
  logic [31:0] word_next;
  logic [3:0]  strb_next;

  assign pix_ready = (!wr_valid || wr_ready) && !restart;
  assign pix_fire  = pix_valid && pix_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign idx       = pal_encode(rgb333_t'(pix_rgb));
  assign word_done = pix_fire && (lane == 2'd3 || pix_last);

  // acc bytes above the current lane are always zero, so a short word is
  // already zero-filled in its unused bytes.
  always_comb begin
    word_next = {8'h00, acc};
    strb_next = 4'b1111;
    case (lane)
      2'd0: begin word_next[7:0]   = idx; strb_next = 4'b0001; end
      2'd1: begin word_next[15:8]  = idx; strb_next = 4'b0011; end
      2'd2: begin word_next[23:16] = idx; strb_next = 4'b0111; end
      default: word_next[31:24] = idx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane        <= '0;
      acc         <= '0;
      last_pend   <= 1'b0;
      rewind_pend <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= BASE;
      wr_data     <= '0;
      wr_strb     <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_fire) begin
        wr_valid    <= 1'b0;
        last_pend   <= 1'b0;
        rewind_pend <= 1'b0;
        wr_addr     <= (last_pend || rewind_pend) ? BASE : wr_addr + addr_t'(1);
        frame_done  <= last_pend && !restart;
      end
      // A restart while a word is stalled lets that word keep its address;
      // the rewind is deferred to its handshake via rewind_pend.
      if (restart) begin
        lane      <= '0;
        acc       <= '0;
        last_pend <= 1'b0;
        if (wr_valid && !wr_ready) rewind_pend <= 1'b1;
        else                       wr_addr     <= BASE;
      end else if (pix_fire) begin
        if (word_done) begin
          wr_data   <= word_next;
          wr_strb   <= strb_next;
          wr_valid  <= 1'b1;
          last_pend <= pix_last;
          lane      <= '0;
          acc       <= '0;
        end else begin
          case (lane)
            2'd0:    acc[7:0]   <= idx;
            2'd1:    acc[15:8]  <= idx;
            default: acc[23:16] <= idx;
          endcase
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_index_packer.sv
// Self-checking bench for rgb_index_packer: directed tables and sequences plus a
// randomized stream checked against a queue-based word model.
`timescale 1ns/1ps
module tb_rgb_index_packer;
  import kinnow_pkg::*;

  localparam int unsigned AW   = 17;
  localparam int unsigned BASE = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          pix_valid = 1'b0, pix_last = 1'b0, restart = 1'b0, wr_ready = 1'b0;
  logic [8:0]    pix_rgb = '0;
  logic          pix_ready, wr_valid, frame_done;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;

  rgb_index_packer #(.ADDR_W(AW), .FB_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_rgb(pix_rgb), .pix_last(pix_last), .restart(restart),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .frame_done(frame_done)
  );

  // Small instance for address wrap-around
  logic        p2_valid = 1'b0, p2_last = 1'b0, r2_restart = 1'b0, w2_ready = 1'b1;
  logic [8:0]  p2_rgb = '0;
  logic        p2_ready, w2_valid, fd2;
  logic [3:0]  w2_addr;
  logic [31:0] w2_data;
  logic [3:0]  w2_strb;

  rgb_index_packer #(.ADDR_W(4), .FB_BASE(14)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pix_valid(p2_valid), .pix_ready(p2_ready),
    .pix_rgb(p2_rgb), .pix_last(p2_last), .restart(r2_restart),
    .wr_valid(w2_valid), .wr_ready(w2_ready), .wr_addr(w2_addr),
    .wr_data(w2_data), .wr_strb(w2_strb), .frame_done(fd2)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          done;
  } wr_t;

  typedef struct {
    logic [8:0] rgb;
    logic [7:0] idx;
  } enc_vec_t;

  int checks = 0;
  int failures = 0;
  wr_t expq[$];
  wr_t wlog[$];
  wr_t mw;
  int unsigned pend[$];
  int unsigned next_addr = BASE;
  int unsigned log2[$];
  bit exp_done = 1'b0;
  int done_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Palette index as plain arithmetic: G*32 + (R/2)*8 + B
  function automatic int unsigned enc(input logic [8:0] p);
    return 32'(p[5:3]) * 32 + 32'(p[8:7]) * 8 + 32'(p[2:0]);
  endfunction

  // RGB333 value whose palette index is i
  function automatic logic [8:0] px(input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return {b[4:3], 1'b0, b[7:5], b[2:0]};
  endfunction

  // Reference model and monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      pend.delete();
      next_addr = BASE;
      exp_done = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(exp_done));
      exp_done = 1'b0;
      if (frame_done) done_count++;
      check("wr_valid", 32'(wr_valid), 32'(expq.size() != 0));
      check("pix_ready", 32'(pix_ready), 32'(!restart && (expq.size() == 0 || wr_ready)));
      if (wr_valid && expq.size() != 0) begin
        check("wr_addr", 32'(wr_addr), expq[0].addr);
        check("wr_data", wr_data, expq[0].data);
        check("wr_strb", 32'(wr_strb), 32'(expq[0].strb));
      end
      if (restart) begin
        foreach (expq[i]) expq[i].done = 1'b0;
        pend.delete();
        next_addr = BASE;
      end
      if (wr_valid && wr_ready) begin
        mw.addr = 32'(wr_addr);
        mw.data = wr_data;
        mw.strb = wr_strb;
        mw.done = 1'b0;
        wlog.push_back(mw);
        if (expq.size() != 0) begin
          exp_done = expq[0].done;
          void'(expq.pop_front());
        end
      end
      if (pix_valid && pix_ready) begin
        pend.push_back(enc(pix_rgb));
        if (pend.size() == PIX_PER_WORD || pix_last) begin
          mw.data = '0;
          foreach (pend[i]) mw.data = mw.data | (32'(pend[i]) << (8 * i));
          mw.strb = 4'((1 << pend.size()) - 1);
          mw.addr = next_addr;
          mw.done = pix_last;
          expq.push_back(mw);
          next_addr = pix_last ? BASE : (next_addr + 1) % (1 << AW);
          pend.delete();
        end
      end
    end
    if (rst_n && w2_valid && w2_ready) log2.push_back(32'(w2_addr));
  end

  task automatic cyc(input bit v, input logic [8:0] rgb, input bit last, input bit rdy,
                     input bit rs, output bit acc);
    pix_valid = v; pix_rgb = rgb; pix_last = last; wr_ready = rdy; restart = rs;
    @(negedge clk);
    acc = pix_valid && pix_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; pix_last = 1'b0; restart = 1'b0; wr_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_w(input int k, input int unsigned addr, input logic [31:0] data,
                       input logic [3:0] strb);
    check("wlog_present", 32'(wlog.size() > k), 32'd1);
    if (wlog.size() > k) begin
      check("log_addr", wlog[k].addr, addr);
      check("log_data", wlog[k].data, data);
      check("log_strb", 32'(wlog[k].strb), 32'(strb));
    end
  endtask

  task automatic chk_reset_outputs();
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_wr_strb", 32'(wr_strb), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    pix_valid = 1'b0; pix_last = 1'b0; restart = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    enc_vec_t    tbl[5];
    bit          a;
    int          n;
    int          d0;
    rgb333_t     c, d, e;

    tbl[0] = '{9'b001_000_001, 8'h01};
    tbl[1] = '{9'b000_000_100, 8'h04};
    tbl[2] = '{9'b010_000_000, 8'h08};
    tbl[3] = '{9'b000_001_000, 8'h20};
    tbl[4] = '{9'b111_111_111, 8'hFF};

    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    rst_n = 1'b1;

    // Palette round trip over all RGB333 values
    for (int unsigned v = 0; v < 512; v++) begin
      c = rgb333_t'(9'(v));
      check("pal_encode", 32'(pal_encode(c)), enc(9'(v)));
      d = pal_decode(pal_encode(c));
      e = c;
      e.r[0] = c.b[0];
      check("pal_roundtrip", 32'(d), 32'(e));
    end

    // Encode table through the datapath, one single-pixel frame each
    foreach (tbl[i]) begin
      wlog.delete();
      cyc(1, tbl[i].rgb, 1, 1, 0, a);
      idle(2);
      chk_w(0, BASE, {24'h0, tbl[i].idx}, 4'b0001);
    end

    // Streaming with no backpressure
    wlog.delete();
    for (int unsigned i = 0; i < 8; i++) begin
      cyc(1, px(i), 0, 1, 0, a);
      check("stream_accept", 32'(a), 32'd1);
    end
    idle(2);
    chk_w(0, BASE,     32'h03020100, 4'b1111);
    chk_w(1, BASE + 1, 32'h07060504, 4'b1111);

    // Partial frame end
    wlog.delete();
    d0 = done_count;
    for (int unsigned i = 0; i < 6; i++) cyc(1, px(8'h30 + i), i == 5, 1, 0, a);
    idle(2);
    chk_w(0, 2, 32'h33323130, 4'b1111);
    chk_w(1, 3, 32'h00003534, 4'b0011);
    check("partial_done", 32'(done_count), 32'(d0 + 1));
    cyc(1, px(8'h40), 1, 1, 0, a);
    idle(2);
    chk_w(2, BASE, 32'h00000040, 4'b0001);

    // Backpressure
    wlog.delete();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, px(8'h50 + n), 0, 0, 0, a);
      if (a) n++;
    end
    check("bp_accepted", 32'(n), 32'd4);
    check("bp_stall", 32'(pix_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, px(8'h50 + n), 0, 1, 0, a);
      check("bp_resume", 32'(a), 32'd1);
      n++;
    end
    idle(2);
    chk_w(0, 0, 32'h53525150, 4'b1111);
    chk_w(1, 1, 32'h57565554, 4'b1111);

    // Restart: partial discard, then restart with a word held
    wlog.delete();
    d0 = done_count;
    for (int unsigned i = 0; i < 6; i++) cyc(1, px(8'h60 + i), 0, 1, 0, a);
    cyc(1, px(8'h66), 0, 1, 1, a);
    check("restart_blocks", 32'(a), 32'd0);
    for (int unsigned i = 0; i < 4; i++) cyc(1, px(8'h10 + i), 0, 1, 0, a);
    idle(1);
    for (int unsigned i = 0; i < 4; i++) cyc(1, px(8'h20 + i), 0, 0, 0, a);
    cyc(0, '0, 0, 0, 1, a);
    idle(1);
    for (int unsigned i = 0; i < 4; i++) cyc(1, px(8'h24 + i), 0, 1, 0, a);
    idle(1);
    for (int unsigned i = 0; i < 4; i++) cyc(1, px(8'h28 + i), i == 3, 0, 0, a);
    cyc(0, '0, 0, 0, 1, a);
    idle(2);
    check("restart_no_done", 32'(done_count), 32'(d0));
    cyc(1, px(8'h2C), 1, 1, 0, a);
    idle(2);
    check("restart_then_done", 32'(done_count), 32'(d0 + 1));
    chk_w(0, 2, 32'h63626160, 4'b1111);
    chk_w(1, 0, 32'h13121110, 4'b1111);
    chk_w(2, 1, 32'h23222120, 4'b1111);
    chk_w(3, 0, 32'h27262524, 4'b1111);
    chk_w(4, 1, 32'h2B2A2928, 4'b1111);
    chk_w(5, 0, 32'h0000002C, 4'b0001);

    // Async reset mid-word, then with a word held
    wlog.delete();
    cyc(1, px(8'h70), 0, 1, 0, a);
    cyc(1, px(8'h71), 0, 1, 0, a);
    pulse_reset();
    cyc(1, px(8'h77), 1, 1, 0, a);
    idle(2);
    chk_w(0, BASE, 32'h00000077, 4'b0001);
    for (int unsigned i = 0; i < 4; i++) cyc(1, px(8'h78 + i), 0, 0, 0, a);
    pulse_reset();
    idle(3);
    check("reset_no_write", 32'(wlog.size()), 32'd1);

    // Randomized stream against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, 9'($urandom), ($urandom % 16) == 0,
          ($urandom % 4) != 0, ($urandom % 50) == 0, a);
    n = 0;
    idle(1);
    while (expq.size() != 0 && n < 20) begin idle(1); n++; end
    check("drain", 32'(expq.size()), 32'd0);

    // Address wrap on the small instance
    for (int unsigned i = 0; i < 12; i++) begin
      p2_valid = 1'b1; p2_rgb = px(i); p2_last = 1'b0;
      @(negedge clk);
      check("wrap_accept", 32'(p2_ready), 32'd1);
      @(posedge clk); #1;
    end
    p2_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("wrap_count", 32'(log2.size()), 32'd3);
    if (log2.size() == 3) begin
      check("wrap_addr0", log2[0], 32'd14);
      check("wrap_addr1", log2[1], 32'd15);
      check("wrap_addr2", log2[2], 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
